// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants, FSM encoding and frame helper
//
// Purpose: constants and types shared by the PS/2 keyboard transmitter, its
// frame serialiser and the scan-code receiver side.
// Contents:
//   PS2_BREAK, PS2_EXT  Set-2 prefix bytes (F0 break, E0 extended)
//   PS2_FRAME_BITS      bits per PS/2 frame (start, 8 data, parity, stop)
//   ps2_state_e         IDLE/LOAD/SEND_HI/SEND_LO/GAP state encoding
//   ps2_frame()         builds the 11-bit frame, bit 0 goes out first
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND_HI = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_GAP     = 3'd4
  } ps2_state_e;

  // {stop, odd parity, d7..d0, start}
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_frame_ser.sv
// rtl/ps2_frame_ser.sv - serialises one byte as an 11-bit PS/2 device frame
//
// Purpose: on start_i, shifts out start/d0..d7/parity/stop. Each bit drives
// data while the clock is high for CLK_DIV cycles, then low for CLK_DIV.
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   start_i           begin a frame with byte_i (taken only when idle)
//   abort_i           drop the frame at once, lines back to idle-high
//   byte_i            byte to send
//   busy_o            frame in progress
//   last_o            final cycle of the stop bit's low phase
//   ps2_clk_o/data_o  registered PS/2 lines
module ps2_frame_ser
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       last_o,
  output logic       ps2_clk_o,
  output logic       ps2_data_o
);

  localparam logic [11:0] PHASE_TOP = 12'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                st_q;
  logic [11:0]               phase_q;
  logic [3:0]                bit_idx_q;
  logic [PS2_FRAME_BITS-1:0] frame_q;
  logic                      clk_q;
  logic                      data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q      <= ST_IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      frame_q   <= '1;
      clk_q     <= 1'b1;
      data_q    <= 1'b1;
    end else if (abort_i) begin
      st_q   <= ST_IDLE;
      clk_q  <= 1'b1;
      data_q <= 1'b1;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (start_i) begin
            frame_q   <= ps2_frame(byte_i);
            data_q    <= 1'b0;
            clk_q     <= 1'b1;
            phase_q   <= PHASE_TOP;
            bit_idx_q <= '0;
            st_q      <= ST_SEND_HI;
          end
        end
        ST_SEND_HI: begin
          if (phase_q == 12'd0) begin
            clk_q   <= 1'b0;
            phase_q <= PHASE_TOP;
            st_q    <= ST_SEND_LO;
          end else begin
            phase_q <= phase_q - 12'd1;
          end
        end
        ST_SEND_LO: begin
          if (phase_q == 12'd0) begin
            if (bit_idx_q < LAST_BIT) begin
              // frame_q[0] is the bit on the wire; the next one sits at [1]
              bit_idx_q <= bit_idx_q + 4'd1;
              data_q    <= frame_q[1];
              frame_q   <= {1'b1, frame_q[PS2_FRAME_BITS-1:1]};
              clk_q     <= 1'b1;
              phase_q   <= PHASE_TOP;
              st_q      <= ST_SEND_HI;
            end else begin
              clk_q  <= 1'b1;
              data_q <= 1'b1;
              st_q   <= ST_IDLE;
            end
          end else begin
            phase_q <= phase_q - 12'd1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = (st_q != ST_IDLE);
  // Lets the sequencer enter its gap on the same edge the lines go idle
  assign last_o     = (st_q == ST_SEND_LO) && (phase_q == 12'd0) && (bit_idx_q == LAST_BIT);
  assign ps2_clk_o  = clk_q;
  assign ps2_data_o = data_q;

endmodule

// File: rtl/ps2_keyboard_tx.sv
// rtl/ps2_keyboard_tx.sv - device-side PS/2 keyboard event transmitter
//
// Purpose: accepts one key event per handshake and sends its Set-2 byte
// sequence ({code}, {E0,code}, {F0,code} or {E0,F0,code}) as PS/2 frames,
// with GAP_CYC idle-high cycles after every byte.
// Ports:
//   clk, rst             system clock, synchronous active-low reset
//   key_valid            event request, taken when ready=1
//   key_code             Set-2 scan code
//   key_ext, key_release E0 prefix / F0 (break) prefix
//   inhibit              host holding the PS/2 clock low
//   ready                idle, can accept an event
//   done                 one-cycle pulse when the last byte's gap ends
//   ps2_clk, ps2_data    PS/2 lines, idle high
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_release,
  input  logic       inhibit,
  output logic       ready,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam logic [11:0] GAP_TOP = 12'(GAP_CYC - 1);

  // ST_SEND_HI here covers the whole frame; the serialiser owns the HI/LO split
  ps2_state_e  state_q;
  logic [23:0] buf_q;    // next byte to send always in [7:0]
  logic [1:0]  cnt_q;    // bytes not yet completed, including the current one
  logic [11:0] gap_q;
  logic        ready_q;
  logic        done_q;

  logic ser_start;
  logic ser_abort;
  logic ser_busy;
  logic ser_last;

  assign ser_start = (state_q == ST_LOAD) && !inhibit;
  assign ser_abort = (state_q == ST_SEND_HI) && inhibit;

  ps2_frame_ser #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .start_i   (ser_start),
    .abort_i   (ser_abort),
    .byte_i    (buf_q[7:0]),
    .busy_o    (ser_busy),
    .last_o    (ser_last),
    .ps2_clk_o (ps2_clk),
    .ps2_data_o(ps2_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Accept wins over inhibit; LOAD then waits for the bus
          if (key_valid) begin
            case ({key_ext, key_release})
              2'b00: begin buf_q <= {16'h0000, key_code};            cnt_q <= 2'd1; end
              2'b10: begin buf_q <= {8'h00, key_code, PS2_EXT};      cnt_q <= 2'd2; end
              2'b01: begin buf_q <= {8'h00, key_code, PS2_BREAK};    cnt_q <= 2'd2; end
              default: begin buf_q <= {key_code, PS2_BREAK, PS2_EXT}; cnt_q <= 2'd3; end
            endcase
            ready_q <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!inhibit) state_q <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (inhibit) begin
            // Byte stays at buf_q[7:0], so LOAD resends it from its start bit
            state_q <= ST_LOAD;
          end else if (ser_last) begin
            buf_q   <= {8'h00, buf_q[23:8]};
            cnt_q   <= cnt_q - 2'd1;
            gap_q   <= GAP_TOP;
            state_q <= ST_GAP;
          end else if (!ser_busy) begin
            state_q <= ST_LOAD;
          end
        end
        ST_GAP: begin
          if (!inhibit) begin
            if (gap_q == 12'd0) begin
              if (cnt_q != 2'd0) begin
                state_q <= ST_LOAD;
              end else begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
                done_q  <= 1'b1;
              end
            end else begin
              gap_q <= gap_q - 12'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb/tb_ps2_keyboard_tx.sv - directed self-checking bench for ps2_keyboard_tx
module tb_ps2_keyboard_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_ext = 1'b0;
  logic       key_release = 1'b0;
  logic       inhibit = 1'b0;
  logic       ready;
  logic       done;
  logic       ps2_clk;
  logic       ps2_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;

  ps2_keyboard_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_release(key_release),
    .inhibit    (inhibit),
    .ready      (ready),
    .done       (done),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data)
  );

  always #5 clk = ~clk;

  // Host-side receiver: samples data on ps2_clk falling edges and drops any
  // partial frame once the clock has idled high longer than one bit time.
  logic        prev_clk = 1'b1;
  int          high_run = 0;
  int          bitcnt = 0;
  logic [10:0] shreg = '0;
  logic [10:0] rx_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    prev_clk <= ps2_clk;
    if (ps2_clk) high_run <= high_run + 1;
    else         high_run <= 0;
    if (ps2_clk && high_run >= 2 * CLK_DIV) begin
      bitcnt <= 0;
    end else if (prev_clk && !ps2_clk) begin
      if (bitcnt == 10) begin
        rx_q.push_back({ps2_data, shreg[10:1]});
        bitcnt <= 0;
      end else begin
        shreg  <= {ps2_data, shreg[10:1]};
        bitcnt <= bitcnt + 1;
      end
    end
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // Returns the edge count at which done was seen, or -1 on timeout
  task automatic wait_done(input string tag, output int at);
    int n;
    n = 0;
    at = -1;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    if (done) at = cyc;
    else chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Accepts on the next edge; returns that edge's count
  task automatic send(input logic [7:0] code, input logic ext, input logic rel, output int k);
    key_code    = code;
    key_ext     = ext;
    key_release = rel;
    key_valid   = 1'b1;
    tick();
    key_valid   = 1'b0;
    k = cyc;
  endtask

  task automatic chk_frame(input string tag, input logic [10:0] exp);
    logic [10:0] f;
    f = 'x;
    if (rx_q.size() > 0) f = rx_q.pop_front();
    chk(tag, 32'(f), 32'(exp));
  endtask

  initial begin
    int k;
    int a;
    int d;
    int d_prev;
    int dc;
    logic saw_done;

    // Reset
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_clk", 32'(ps2_clk), 32'd1);
    chk("rst_data", 32'(ps2_data), 32'd1);
    rst = 1'b1;
    repeat (2) tick();

    // Make 0x1C
    dc = done_cnt;
    send(8'h1C, 1'b0, 1'b0, k);
    chk("make_ready_low", 32'(ready), 32'd0);
    tick();
    chk("make_start_data", 32'(ps2_data), 32'd0);
    chk("make_start_clk", 32'(ps2_clk), 32'd1);
    wait_done("make", d);
    chk("make_latency", 32'(d - k), 32'd97);
    tick();
    chk("make_done_pulse", 32'(done), 32'd0);
    chk("make_ready_back", 32'(ready), 32'd1);
    chk("make_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("make_rx_n", 32'(rx_q.size()), 32'd1);
    chk_frame("make_bits", 11'h438);

    // Break 0x1C
    dc = done_cnt;
    send(8'h1C, 1'b0, 1'b1, k);
    wait_done("brk", d);
    chk("brk_latency", 32'(d - k), 32'd194);
    tick();
    chk("brk_rx_n", 32'(rx_q.size()), 32'd2);
    chk_frame("brk_f0", 11'h7E0);
    chk_frame("brk_code", exp_frame(8'h1C));
    chk("brk_done_cnt", 32'(done_cnt - dc), 32'd1);

    // Extended break 0x75, stray key_valid mid-sequence
    dc = done_cnt;
    send(8'h75, 1'b1, 1'b1, k);
    wait_until(k + 100);
    key_code  = 8'h16;
    key_ext   = 1'b0;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_done("ext", d);
    chk("ext_latency", 32'(d - k), 32'd291);
    repeat (120) tick();
    chk("ext_rx_n", 32'(rx_q.size()), 32'd3);
    chk_frame("ext_e0", exp_frame(8'hE0));
    chk_frame("ext_f0", exp_frame(8'hF0));
    chk_frame("ext_code", exp_frame(8'h75));
    chk("ext_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("ext_ready_idle", 32'(ready), 32'd1);

    // Inhibit during d3 of the F0 frame (F0 starts at edge k+98)
    dc = done_cnt;
    send(8'h75, 1'b1, 1'b1, k);
    wait_until(k + 133);
    inhibit = 1'b1;
    tick();
    a = cyc;
    chk("inh_clk_high", 32'(ps2_clk), 32'd1);
    chk("inh_data_high", 32'(ps2_data), 32'd1);
    repeat (10) tick();
    chk("inh_hold_clk", 32'(ps2_clk), 32'd1);
    chk("inh_hold_data", 32'(ps2_data), 32'd1);
    repeat (9) tick();
    inhibit = 1'b0;
    wait_done("inh", d);
    chk("inh_latency", 32'(d - a), 32'd213);
    tick();
    chk("inh_rx_n", 32'(rx_q.size()), 32'd3);
    chk_frame("inh_e0", exp_frame(8'hE0));
    chk_frame("inh_f0", exp_frame(8'hF0));
    chk_frame("inh_code", exp_frame(8'h75));
    chk("inh_done_cnt", 32'(done_cnt - dc), 32'd1);

    // Reset during d5 of a frame
    dc = done_cnt;
    send(8'h1C, 1'b0, 1'b0, k);
    wait_until(k + 51);
    rst = 1'b0;
    tick();
    chk("mrst_clk", 32'(ps2_clk), 32'd1);
    chk("mrst_data", 32'(ps2_data), 32'd1);
    chk("mrst_ready", 32'(ready), 32'd1);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (150) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("mrst_no_done", 32'(saw_done), 32'd0);
    chk("mrst_rx_n", 32'(rx_q.size()), 32'd0);
    send(8'h16, 1'b0, 1'b0, k);
    wait_done("post_rst", d);
    chk("post_rst_latency", 32'(d - k), 32'd97);
    tick();
    chk("post_rst_rx_n", 32'(rx_q.size()), 32'd1);
    chk_frame("post_rst_code", exp_frame(8'h16));

    // Back-to-back with key_valid held high
    dc = done_cnt;
    key_ext     = 1'b0;
    key_release = 1'b0;
    key_code    = 8'h1C;
    key_valid   = 1'b1;
    tick();
    k = cyc;
    wait_done("b2b_1", d);
    chk("b2b_lat1", 32'(d - k), 32'd97);
    key_code = 8'h32;
    d_prev = d;
    tick();
    wait_done("b2b_2", d);
    chk("b2b_lat2", 32'(d - d_prev), 32'd98);
    key_code = 8'h21;
    d_prev = d;
    tick();
    wait_done("b2b_3", d);
    chk("b2b_lat3", 32'(d - d_prev), 32'd98);
    key_valid = 1'b0;
    repeat (20) tick();
    chk("b2b_done_cnt", 32'(done_cnt - dc), 32'd3);
    chk("b2b_rx_n", 32'(rx_q.size()), 32'd3);
    chk_frame("b2b_c1", exp_frame(8'h1C));
    chk_frame("b2b_c2", exp_frame(8'h32));
    chk_frame("b2b_c3", exp_frame(8'h21));
    chk("b2b_ready", 32'(ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_tx.md
Name: ps2_keyboard_tx

Overview:
- Device-side PS/2 keyboard transmitter: the keyboard end of the link our scan-code receiver/display path consumes.
- Takes one key event per handshake (code, extended flag, press/release).
- Emits the Set-2 byte sequence as 11-bit PS/2 frames on ps2_clk/ps2_data.
- Used as an on-chip stimulus source for the keyboard display path and as the keyboard model in simulation.

Parameters:
- CLK_DIV, 4, system cycles per PS/2 clock half-period (high phase = low phase = CLK_DIV); legal range 2 to 4095.
- GAP_CYC, 8, idle cycles (clk=1, data=1) between consecutive bytes of one event; legal range 1 to 4095.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-low.
- key_valid  in  1  event request.
- key_code  in  8  Set-2 scan code.
- key_ext  in  1  prefix the event with E0.
- key_release  in  1  1 = break event (F0 prefix), 0 = make event.
- inhibit  in  1  host holding PS/2 clock low.
- ready  out  1  block can accept an event.
- done  out  1  one-cycle pulse when the last byte's gap ends.
- ps2_clk  out  1  PS/2 clock, idle 1.
- ps2_data  out  1  PS/2 data, idle 1.

Behaviour:
- Reset (rst=0 at a clk edge): ready=1, done=0, ps2_clk=1, ps2_data=1, FSM=IDLE, byte buffer cleared. This applies mid-frame too; the partial frame is abandoned, with no completion.
- Accept: key_valid && ready at a clk edge. Latch the sequence and set ready=0 from the next cycle. key_valid while ready=0 is ignored; there is no queue.
- Byte sequences:
  - make, non-ext: {code}
  - make, ext: {E0, code}
  - break, non-ext: {F0, code}
  - break, ext: {E0, F0, code}
  - Buffer holds 3 bytes plus a 2-bit count.
- Frame: start 0, d0..d7 (LSB first), odd parity (~^byte), stop 1.
  - Each bit: ps2_data updates at bit start while ps2_clk=1.
  - ps2_clk is then 1 for CLK_DIV cycles and 0 for CLK_DIV cycles.
  - The receiver samples on the falling edge.
  - Frame length is 22*CLK_DIV cycles.
- FSM states: IDLE -> LOAD (1 cycle; select next byte, compute parity, bit_idx=0) -> SEND_HI -> SEND_LO -> …
  - SEND_LO exits to SEND_HI if bit_idx<10, with bit_idx+1.
  - SEND_LO exits to GAP if bit_idx==10.
  - GAP (GAP_CYC cycles, lines high) -> LOAD if bytes remain, else IDLE.
  - done=1 on the GAP->IDLE transition cycle; ready=1 in IDLE.
  - First ps2_data=0 (start bit) appears 1 cycle after accept (the LOAD cycle), lasting 2*CLK_DIV cycles from its SEND_HI entry.
- inhibit:
  - In IDLE/LOAD: an accept is still latched, but the FSM holds in LOAD while inhibit=1.
  - In SEND_HI/SEND_LO: abort the current frame. Drive ps2_clk=1 and ps2_data=1, return to LOAD, and retransmit the same byte from its start bit after inhibit falls. Already-completed bytes are not resent.
  - In GAP: the counter pauses while inhibit=1.
  - inhibit and accept in the same cycle: accept wins; the event is latched.
- Counters:
  - Phase counter is 12 bits, counting CLK_DIV-1 down to 0.
  - bit_idx is 4 bits, saturating at 10.
  - No wrap beyond legal parameter ranges.
- All outputs are registered; no combinational path from inputs to ps2_clk/ps2_data.

Decomposition:
- Shared package ps2_pkg:
  - PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
  - FSM state encoding (IDLE, LOAD, SEND_HI, SEND_LO, GAP).
  - Frame length constant 11.
  - The receiver side reuses PS2_BREAK.
- One sub-module, ps2_frame_ser:
  - Serialises a single byte.
  - Interface: start/busy/abort in, the byte in, clk/data out.
  - ps2_keyboard_tx keeps the sequencing, gap and handshake.

Test Plan:
- Setup: CLK_DIV=4, GAP_CYC=8.
- Make 0x1C (key_ext=0, key_release=0) -> one frame, falling-edge samples 0,0,0,1,1,1,0,0,0,0,1 (parity 0); 88 cycles of SEND plus 8 GAP; done pulses once; ready returns 1.
- Break 0x1C -> frames F0 (parity 1) then 1C; 8-cycle all-high gap between them; done after the second gap.
- Extended break 0x75 -> E0 (parity 0), F0 (parity 1), 75 (parity 0); total 3*96 cycles after LOAD cycles; a key_valid pulse mid-sequence is ignored.
- inhibit=1 for 20 cycles during d3 of the F0 frame -> lines go high within 1 cycle; F0 is resent from its start bit after release; E0 is not resent; the receiver sees E0,F0,75.
- rst=0 during d5 of the first frame -> next cycle ps2_clk=1, ps2_data=1, ready=1, done never pulses; a new event of 0x16 then transmits cleanly.
- Back-to-back: key_valid held high continuously -> events are accepted only in IDLE cycles, one per done; the receiver decodes matching codes.
